// File: rtl/vcm_i2c_responder.sv
// I2C target emulating the VCM focus-driver chip: accepts 2-byte writes into a
// 16-bit register and returns that register on reads. Open-drain SDA via SDA_OE.
module vcm_i2c_responder #(
    parameter logic [6:0]  DEV_ADDR = 7'h0C,
    parameter logic [15:0] RST_DATA = 16'h0000,
    parameter int          SYNC_STG = 2
) (
    input  logic        CLK_50,
    input  logic        RESET_N,
    input  logic        SCL_IN,
    input  logic        SDA_IN,
    output logic        SDA_OE,
    output logic [15:0] VCM_DATA,
    output logic        VCM_UPDATE,
    output logic        BUSY,
    output logic [7:0]  NACK_CNT
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_BYTE  = 3'd3;
    localparam logic [2:0] ST_WR_ACK   = 3'd4;
    localparam logic [2:0] ST_RD_BYTE  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    logic [SYNC_STG-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STG-1:0] sda_sync_q, sda_sync_d;
    logic                scl_hist_q, sda_hist_q;
    logic                scl_s, sda_s;
    logic                scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]          byte_nxt;

    logic [2:0]  state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic        ack_rise_q, ack_rise_d;
    logic        rd_lo_q, rd_lo_d;
    logic [7:0]  hold_q, hold_d;
    logic [15:0] vcm_q, vcm_d;
    logic        upd_q, upd_d;
    logic        busy_q, busy_d;
    logic [7:0]  nack_q, nack_d;
    logic        oe_q, oe_d;

    // Next value of the synchronizer chains
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STG-2:0], SCL_IN};
        sda_sync_d = {sda_sync_q[SYNC_STG-2:0], SDA_IN};
    end

    // Synchronizer and history flops; idle bus level is high
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            scl_sync_q <= {SYNC_STG{1'b1}};
            sda_sync_q <= {SYNC_STG{1'b1}};
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_s;
            sda_hist_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STG-1];
    assign sda_s     = sda_sync_q[SYNC_STG-1];
    assign scl_rise  = scl_s & ~scl_hist_q;
    assign scl_fall  = ~scl_s & scl_hist_q;
    assign start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
    assign stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    assign byte_nxt  = {shift_q[6:0], sda_s};

    // Protocol state machine; START/STOP take priority over any bit in progress
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        ack_rise_d = ack_rise_q;
        rd_lo_d    = rd_lo_q;
        hold_d     = hold_q;
        vcm_d      = vcm_q;
        upd_d      = 1'b0;
        busy_d     = busy_q;
        nack_d     = nack_q;
        oe_d       = oe_q;
        if (stop_det) begin
            state_d    = ST_IDLE;
            oe_d       = 1'b0;
            busy_d     = 1'b0;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 2'd0;
            ack_rise_d = 1'b0;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            oe_d       = 1'b0;
            bit_cnt_d  = 4'd0;
            byte_cnt_d = 2'd0;
            ack_rise_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_nxt;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (byte_nxt[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d = ST_IGNORE;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                // First SCL fall drives the ACK, the fall after the 9th rise ends it
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_rise) begin
                        ack_rise_d = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_rise_q) begin
                            oe_d = 1'b1;
                        end else begin
                            ack_rise_d = 1'b0;
                            bit_cnt_d  = 4'd0;
                            if ((state_q == ST_ADDR_ACK) && shift_q[0]) begin
                                state_d = ST_RD_BYTE;
                                shift_d = vcm_q[15:8];
                                oe_d    = ~vcm_q[15];
                                rd_lo_d = 1'b1;
                            end else begin
                                state_d = ST_WR_BYTE;
                                oe_d    = 1'b0;
                            end
                        end
                    end else begin
                        ack_rise_d = ack_rise_q;
                    end
                end
                ST_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = byte_nxt;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d  = 4'd0;
                            ack_rise_d = 1'b0;
                            case (byte_cnt_q)
                                2'd0: begin
                                    hold_d     = byte_nxt;
                                    byte_cnt_d = 2'd1;
                                    state_d    = ST_WR_ACK;
                                end
                                2'd1: begin
                                    vcm_d      = {hold_q, byte_nxt};
                                    upd_d      = 1'b1;
                                    byte_cnt_d = 2'd2;
                                    state_d    = ST_WR_ACK;
                                end
                                default: begin
                                    nack_d  = (nack_q != 8'hFF) ? nack_q + 8'd1 : nack_q;
                                    state_d = ST_IGNORE;
                                end
                            endcase
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = ST_WR_BYTE;
                    end
                end
                ST_RD_BYTE: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d       = 1'b0;
                            bit_cnt_d  = 4'd0;
                            ack_rise_d = 1'b0;
                            state_d    = ST_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end else begin
                        state_d = ST_RD_BYTE;
                    end
                end
                // Master ACK reloads the shifter, alternating low then high byte
                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ack_rise_d = 1'b1;
                            shift_d    = rd_lo_q ? vcm_q[7:0] : vcm_q[15:8];
                            rd_lo_d    = ~rd_lo_q;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && ack_rise_q) begin
                        oe_d       = ~shift_q[7];
                        ack_rise_d = 1'b0;
                        bit_cnt_d  = 4'd0;
                        state_d    = ST_RD_BYTE;
                    end else begin
                        state_d = ST_RD_ACK;
                    end
                end
                ST_IGNORE: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // Protocol and output registers
    always_ff @(posedge CLK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= 2'd0;
            ack_rise_q <= 1'b0;
            rd_lo_q    <= 1'b0;
            hold_q     <= 8'h00;
            vcm_q      <= RST_DATA;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 8'h00;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ack_rise_q <= ack_rise_d;
            rd_lo_q    <= rd_lo_d;
            hold_q     <= hold_d;
            vcm_q      <= vcm_d;
            upd_q      <= upd_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
            oe_q       <= oe_d;
        end
    end

    assign SDA_OE     = oe_q;
    assign VCM_DATA   = vcm_q;
    assign VCM_UPDATE = upd_q;
    assign BUSY       = busy_q;
    assign NACK_CNT   = nack_q;

endmodule

// File: tb/tb_vcm_i2c_responder.sv
// Bench for vcm_i2c_responder: a bit-banged I2C master plus a transaction-level
// model of the VCM register, compared against the DUT every settled cycle.
`timescale 1ns/1ps
module tb_vcm_i2c_responder;

    localparam logic [15:0] RST_VAL = 16'hA5C3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_oe;
    logic [15:0] vcm;
    logic        upd;
    logic        busy;
    logic [7:0]  nack;

    assign sda_bus = sda_m & ~sda_oe;

    vcm_i2c_responder #(
        .DEV_ADDR(7'h0C),
        .RST_DATA(RST_VAL),
        .SYNC_STG(2)
    ) dut (
        .CLK_50    (clk),
        .RESET_N   (rst_n),
        .SCL_IN    (scl_m),
        .SDA_IN    (sda_bus),
        .SDA_OE    (sda_oe),
        .VCM_DATA  (vcm),
        .VCM_UPDATE(upd),
        .BUSY      (busy),
        .NACK_CNT  (nack)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int half = 63;
    int cyc = 0;
    int hold_until = 0;
    int upd_seen = 0;
    int oe_seen = 0;

    // transaction-level model of the target
    logic [15:0] m_vcm;
    logic [7:0]  m_nack;
    logic        m_busy;
    logic [7:0]  m_hold;
    logic        m_active;
    int          m_idx;
    int          m_rd_idx;
    int          m_upd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        hold_until = cyc + half + 12;
    endtask

    task automatic m_reset();
        m_vcm = RST_VAL; m_nack = 8'd0; m_busy = 1'b0; m_active = 1'b0;
        m_idx = 0; m_rd_idx = 0; m_hold = 8'h00;
    endtask

    task automatic m_addr(input logic [7:0] b, output logic exp_ack);
        settle();
        m_active = (b[7:1] == 7'h0C);
        m_busy = m_active;
        m_idx = 0;
        m_rd_idx = 0;
        exp_ack = !m_active;
    endtask

    task automatic m_wr(input logic [7:0] b, output logic exp_ack);
        settle();
        exp_ack = 1'b1;
        if (m_active) begin
            if (m_idx == 0) begin
                m_hold = b; exp_ack = 1'b0;
            end else if (m_idx == 1) begin
                m_vcm = {m_hold, b}; m_upd++; exp_ack = 1'b0;
            end else begin
                if (m_nack != 8'd255) m_nack = m_nack + 8'd1;
                m_active = 1'b0;
            end
            m_idx++;
        end
    endtask

    task automatic m_rd(output logic [7:0] e);
        e = (m_rd_idx % 2 == 0) ? m_vcm[15:8] : m_vcm[7:0];
        m_rd_idx++;
    endtask

    task automatic m_stop();
        settle();
        m_busy = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cyc++;
            if (upd) upd_seen++;
            if (sda_oe) oe_seen++;
            if (rst_n && cyc >= hold_until) begin
                check("vcm_data", vcm, m_vcm);
                check("nack_cnt", nack, m_nack);
                check("busy", busy, m_busy);
            end
        end
    endtask

    task automatic bit_x(input logic b, output logic r, output logic o);
        sda_m = b;
        wclk(half / 2);
        scl_m = 1'b1;
        wclk(half / 2);
        r = sda_bus;
        o = sda_oe;
        wclk(half - half / 2);
        scl_m = 1'b0;
        wclk(half - half / 2);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        wclk(half / 2);
        scl_m = 1'b1;
        wclk(half);
        sda_m = 1'b0;
        wclk(half);
        scl_m = 1'b0;
        wclk(half - half / 2);
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        wclk(half / 2);
        scl_m = 1'b1;
        wclk(half);
        m_stop();
        sda_m = 1'b1;
        wclk(half);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic is_addr, input string tag);
        logic r, o, ea;
        for (int i = 7; i >= 1; i--) bit_x(b[i], r, o);
        if (is_addr) m_addr(b, ea); else m_wr(b, ea);
        bit_x(b[0], r, o);
        bit_x(1'b1, r, o);
        check(tag, r, ea);
    endtask

    task automatic rd_byte(input logic ack, input string tag, output logic [7:0] d);
        logic r, o;
        logic [7:0] e;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r, o);
            d[i] = r;
        end
        m_rd(e);
        check(tag, d, e);
        bit_x(ack, r, o);
        check({tag, "_released"}, o, 1'b0);
    endtask

    initial begin
        int u0, o0;
        logic r, o, ea;
        logic [7:0] d;
        m_reset();
        fork
            compare_loop();
        join_none
        wclk(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_vcm", vcm, RST_VAL);
        check("rst_upd", upd, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_nack", nack, 8'd0);
        rst_n = 1'b1;
        wclk(5);

        // 100 kHz full write
        half = 250;
        u0 = upd_seen;
        start_c();
        wr_byte(8'h18, 1'b1, "t1_addr_ack");
        wr_byte(8'h03, 1'b0, "t1_b1_ack");
        wr_byte(8'hFF, 1'b0, "t1_b2_ack");
        stop_c();
        wclk(20);
        check("t1_vcm", vcm, 16'h03FF);
        check("t1_upd_pulses", upd_seen - u0, 1);
        check("t1_busy_after_stop", busy, 1'b0);

        // write then repeated-START read of two bytes
        half = 63;
        u0 = upd_seen;
        start_c();
        wr_byte(8'h18, 1'b1, "t2_addr_ack");
        wr_byte(8'h12, 1'b0, "t2_b1_ack");
        wr_byte(8'h34, 1'b0, "t2_b2_ack");
        start_c();
        wr_byte(8'h19, 1'b1, "t2_raddr_ack");
        rd_byte(1'b0, "t2_rd0", d);
        check("t2_rd0_lit", d, 8'h12);
        rd_byte(1'b1, "t2_rd1", d);
        check("t2_rd1_lit", d, 8'h34);
        check("t2_busy_until_stop", busy, 1'b1);
        stop_c();
        wclk(20);
        check("t2_busy_after_stop", busy, 1'b0);
        check("t2_upd_pulses", upd_seen - u0, 1);

        // other device address
        u0 = upd_seen;
        o0 = oe_seen;
        start_c();
        wr_byte(8'h1A, 1'b1, "t3_addr_noack");
        wr_byte(8'h55, 1'b0, "t3_b1_noack");
        wr_byte(8'h66, 1'b0, "t3_b2_noack");
        stop_c();
        wclk(20);
        check("t3_oe_cycles", oe_seen - o0, 0);
        check("t3_vcm", vcm, 16'h1234);
        check("t3_upd_pulses", upd_seen - u0, 0);

        // partial write discarded
        u0 = upd_seen;
        start_c();
        wr_byte(8'h18, 1'b1, "t4_addr_ack");
        wr_byte(8'hAB, 1'b0, "t4_b1_ack");
        stop_c();
        wclk(20);
        check("t4_vcm", vcm, 16'h1234);
        check("t4_upd_pulses", upd_seen - u0, 0);

        // third data byte NACKed
        start_c();
        wr_byte(8'h18, 1'b1, "t5_addr_ack");
        wr_byte(8'h01, 1'b0, "t5_b1_ack");
        wr_byte(8'h02, 1'b0, "t5_b2_ack");
        wr_byte(8'h03, 1'b0, "t5_b3_nack");
        stop_c();
        wclk(20);
        check("t5_vcm", vcm, 16'h0102);
        check("t5_nack_cnt", nack, 8'd1);

        // reset during the ACK of data byte 1, then a fresh write
        start_c();
        wr_byte(8'h18, 1'b1, "t6_addr_ack");
        for (int i = 7; i >= 1; i--) bit_x(d[0] ^ 1'b1 ? 1'b0 : 1'b0, r, o);
        m_wr(8'h00, ea);
        bit_x(1'b0, r, o);
        sda_m = 1'b1;
        wclk(half / 2);
        scl_m = 1'b1;
        wclk(half / 2);
        check("t6_ack_driven", sda_oe, 1'b1);
        hold_until = cyc + 1000000;
        rst_n = 1'b0;
        #1;
        check("t6_oe_async", sda_oe, 1'b0);
        check("t6_vcm_rst", vcm, RST_VAL);
        m_reset();
        wclk(5);
        rst_n = 1'b1;
        wclk(half);
        scl_m = 1'b0;
        wclk(half);
        hold_until = cyc + 2;
        stop_c();
        start_c();
        wr_byte(8'h18, 1'b1, "t6b_addr_ack");
        wr_byte(8'h00, 1'b0, "t6b_b1_ack");
        wr_byte(8'h80, 1'b0, "t6b_b2_ack");
        stop_c();
        wclk(20);
        check("t6_vcm", vcm, 16'h0080);
        check("t6_busy", busy, 1'b0);
        check("t6_nack_cnt", nack, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
